// File: rtl/mem_port_arbiter.sv
// Arbitrates one shared memory port between a fetch requester and a data requester,
// with one transaction in flight and a bounded run of data grants while fetch waits.
module mem_port_arbiter #(
  parameter int unsigned MAX_D_STREAK = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [3:0]  d_be,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        err_spurious
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP} state_t;
  typedef enum logic {OWN_DATA, OWN_FETCH} owner_t;

  localparam logic [3:0] STREAK_MAX = 4'(MAX_D_STREAK);

  state_t     state, state_nxt;
  owner_t     owner, owner_nxt;
  logic [3:0] streak, streak_nxt;
  logic       fetch_wins;

  // Fetch only beats a pending data request once data has used up its streak.
  assign fetch_wins = if_req && (!d_req || streak == STREAK_MAX);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      owner  <= OWN_DATA;
      streak <= '0;
    end else begin
      state  <= state_nxt;
      owner  <= owner_nxt;
      streak <= streak_nxt;
    end
  end

  // NOTE: every comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt  = state;
    owner_nxt  = owner;
    streak_nxt = streak;
    unique case (state)
      IDLE: begin
        if (if_req || d_req) begin
          state_nxt = REQ;
          owner_nxt = fetch_wins ? OWN_FETCH : OWN_DATA;
        end
      end
      REQ: begin
        if (mem_gnt) begin
          state_nxt = WAIT_RSP;
          if (owner == OWN_FETCH) begin
            streak_nxt = '0;
          end else if (if_req && streak < STREAK_MAX) begin
            streak_nxt = streak + 4'd1;
          end
        end
      end
      WAIT_RSP: begin
        if (mem_rvalid) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are forced low throughout reset, including the cycle reset is first seen.
  always_comb begin
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_be       = 4'h0;
    mem_addr     = '0;
    mem_wdata    = '0;
    if_gnt       = 1'b0;
    d_gnt        = 1'b0;
    if_rvalid    = 1'b0;
    if_rdata     = '0;
    d_rvalid     = 1'b0;
    d_rdata      = '0;
    err_spurious = 1'b0;
    if (!rst) begin
      err_spurious = mem_rvalid && (state != WAIT_RSP);
      unique case (state)
        REQ: begin
          mem_req = 1'b1;
          if (owner == OWN_FETCH) begin
            mem_be   = 4'hF;
            mem_addr = if_addr;
            if_gnt   = mem_gnt;
          end else begin
            mem_we    = d_we;
            mem_be    = d_be;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
            d_gnt     = mem_gnt;
          end
        end
        WAIT_RSP: begin
          if (mem_rvalid) begin
            if (owner == OWN_FETCH) begin
              if_rvalid = 1'b1;
              if_rdata  = mem_rdata;
            end else begin
              d_rvalid = 1'b1;
              d_rdata  = mem_rdata;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
